// File: rtl/instr_decoder.sv
// Instruction decoder for the 16-bit riskHDL CPU: decodes opcode, f2 and
// branch-condition fields into registered one-hot strobes plus ILLEGAL.
module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic        ADD,
  output logic        ADC,
  output logic        SUB,
  output logic        SBB,
  output logic        SUBI,
  output logic        ADDI,
  output logic        CMP,
  output logic        MOV,
  output logic        LDR,
  output logic        LDRI,
  output logic        STR,
  output logic        STRI,
  output logic        LLI,
  output logic        LHI,
  output logic        BEQ,
  output logic        BNE,
  output logic        BCS,
  output logic        BCC,
  output logic        BAL,
  output logic        JMP,
  output logic        JALI,
  output logic        JAL,
  output logic        JR,
  output logic        OUTR,
  output logic        HLT,
  output logic        ILLEGAL
);

  // Bit positions of each strobe inside the internal one-hot vector.
  localparam int SADD  = 0;
  localparam int SADC  = 1;
  localparam int SSUB  = 2;
  localparam int SSBB  = 3;
  localparam int SSUBI = 4;
  localparam int SADDI = 5;
  localparam int SCMP  = 6;
  localparam int SMOV  = 7;
  localparam int SLDR  = 8;
  localparam int SLDRI = 9;
  localparam int SSTR  = 10;
  localparam int SSTRI = 11;
  localparam int SLLI  = 12;
  localparam int SLHI  = 13;
  localparam int SBEQ  = 14;
  localparam int SBNE  = 15;
  localparam int SBCS  = 16;
  localparam int SBCC  = 17;
  localparam int SBAL  = 18;
  localparam int SJMP  = 19;
  localparam int SJALI = 20;
  localparam int SJAL  = 21;
  localparam int SJR   = 22;
  localparam int SOUTR = 23;
  localparam int SHLT  = 24;
  localparam int NSTROBES = 25;

  logic [4:0]          opcode;
  logic [1:0]          f2;
  logic [3:0]          cond;
  logic [NSTROBES-1:0] decoded;
  logic                illegal;
  logic [NSTROBES-1:0] strobes;
  logic                illegalq;
  logic                unusedbits;

  assign opcode = instr[15:11];
  assign f2     = instr[1:0];
  assign cond   = instr[11:8];

  // Register and immediate fields never influence the decode.
  assign unusedbits = ^instr[7:2];

  // Combinational decode of the current word into a one-hot strobe or ILLEGAL.
  always_comb begin
    decoded = '0;
    illegal = 1'b0;
    casez (opcode)
      5'b00000: begin
        case (f2)
          2'b00:   decoded[SADD] = 1'b1;
          2'b01:   decoded[SADC] = 1'b1;
          2'b10:   decoded[SSUB] = 1'b1;
          default: decoded[SSBB] = 1'b1;
        endcase
      end
      5'b00001: decoded[SLHI]  = 1'b1;
      5'b00010: decoded[SLLI]  = 1'b1;
      5'b00011: decoded[SLDRI] = 1'b1;
      5'b00100: decoded[SLDR]  = 1'b1;
      5'b00101: decoded[SSTRI] = 1'b1;
      5'b00110: begin
        case (f2)
          2'b00:   decoded[SSTR] = 1'b1;
          2'b01:   decoded[SCMP] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      5'b00111: decoded[SADDI] = 1'b1;
      5'b01000: decoded[SSUBI] = 1'b1;
      5'b01011: decoded[SMOV]  = 1'b1;
      5'b10000: decoded[SJMP]  = 1'b1;
      5'b10001: decoded[SJALI] = 1'b1;
      5'b10010: decoded[SJAL]  = 1'b1;
      5'b10011: decoded[SJR]   = 1'b1;
      5'b11100: begin
        case (f2)
          2'b00:   decoded[SOUTR] = 1'b1;
          2'b01:   decoded[SHLT]  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      // Branch group keys on instr[15:12] only; instr[11] belongs to cond.
      5'b1100?: begin
        case (cond)
          4'b0000: decoded[SBEQ] = 1'b1;
          4'b0001: decoded[SBNE] = 1'b1;
          4'b0010: decoded[SBCS] = 1'b1;
          4'b0011: decoded[SBCC] = 1'b1;
          4'b1110: decoded[SBAL] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // Output register: one-cycle decode latency, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobes  <= '0;
      illegalq <= 1'b0;
    end else begin
      strobes  <= decoded;
      illegalq <= illegal;
    end
  end

  assign ADD     = strobes[SADD];
  assign ADC     = strobes[SADC];
  assign SUB     = strobes[SSUB];
  assign SBB     = strobes[SSBB];
  assign SUBI    = strobes[SSUBI];
  assign ADDI    = strobes[SADDI];
  assign CMP     = strobes[SCMP];
  assign MOV     = strobes[SMOV];
  assign LDR     = strobes[SLDR];
  assign LDRI    = strobes[SLDRI];
  assign STR     = strobes[SSTR];
  assign STRI    = strobes[SSTRI];
  assign LLI     = strobes[SLLI];
  assign LHI     = strobes[SLHI];
  assign BEQ     = strobes[SBEQ];
  assign BNE     = strobes[SBNE];
  assign BCS     = strobes[SBCS];
  assign BCC     = strobes[SBCC];
  assign BAL     = strobes[SBAL];
  assign JMP     = strobes[SJMP];
  assign JALI    = strobes[SJALI];
  assign JAL     = strobes[SJAL];
  assign JR      = strobes[SJR];
  assign OUTR    = strobes[SOUTR];
  assign HLT     = strobes[SHLT];
  assign ILLEGAL = illegalq;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed encodings, reset behaviour
// and randomized words compared against a name-based reference decoder.
module tb_instr_decoder;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic ADD, ADC, SUB, SBB, SUBI, ADDI, CMP, MOV;
  logic LDR, LDRI, STR, STRI, LLI, LHI;
  logic BEQ, BNE, BCS, BCC, BAL;
  logic JMP, JALI, JAL, JR;
  logic OUTR, HLT, ILLEGAL;

  int checkCount = 0;
  int passCount  = 0;

  // Observed outputs packed in the order of the names table below.
  logic [25:0] observed;
  assign observed = {ILLEGAL, HLT, OUTR, JR, JAL, JALI, JMP, BAL, BCC, BCS, BNE, BEQ,
                     LHI, LLI, STRI, STR, LDRI, LDR, MOV, CMP, ADDI, SUBI, SBB, SUB,
                     ADC, ADD};

  string names [26] = '{"ADD", "ADC", "SUB", "SBB", "SUBI", "ADDI", "CMP", "MOV",
                        "LDR", "LDRI", "STR", "STRI", "LLI", "LHI",
                        "BEQ", "BNE", "BCS", "BCC", "BAL",
                        "JMP", "JALI", "JAL", "JR", "OUTR", "HLT", "ILLEGAL"};

  instr_decoder dut (
    .clk(clk), .rst(rst), .instr(instr),
    .ADD(ADD), .ADC(ADC), .SUB(SUB), .SBB(SBB), .SUBI(SUBI), .ADDI(ADDI),
    .CMP(CMP), .MOV(MOV), .LDR(LDR), .LDRI(LDRI), .STR(STR), .STRI(STRI),
    .LLI(LLI), .LHI(LHI), .BEQ(BEQ), .BNE(BNE), .BCS(BCS), .BCC(BCC),
    .BAL(BAL), .JMP(JMP), .JALI(JALI), .JAL(JAL), .JR(JR), .OUTR(OUTR),
    .HLT(HLT), .ILLEGAL(ILLEGAL)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Look up a mnemonic's position in the names table.
  function automatic int nameIndex(input string n);
    for (int i = 0; i < 26; i++) if (names[i] == n) return i;
    return 25;
  endfunction

  // Reference decoder: derives the mnemonic from the ISA rules with arithmetic fields.
  function automatic string refName(input logic [15:0] w);
    int op;
    int f;
    int c;
    op = int'(w) / 2048;
    f  = int'(w) % 4;
    c  = (int'(w) / 256) % 16;
    if (op / 2 == 12) begin
      if (c == 0)  return "BEQ";
      if (c == 1)  return "BNE";
      if (c == 2)  return "BCS";
      if (c == 3)  return "BCC";
      if (c == 14) return "BAL";
      return "ILLEGAL";
    end
    case (op)
      0:  return (f == 0) ? "ADD" : (f == 1) ? "ADC" : (f == 2) ? "SUB" : "SBB";
      1:  return "LHI";
      2:  return "LLI";
      3:  return "LDRI";
      4:  return "LDR";
      5:  return "STRI";
      6:  return (f == 0) ? "STR" : (f == 1) ? "CMP" : "ILLEGAL";
      7:  return "ADDI";
      8:  return "SUBI";
      11: return "MOV";
      16: return "JMP";
      17: return "JALI";
      18: return "JAL";
      19: return "JR";
      28: return (f == 0) ? "OUTR" : (f == 1) ? "HLT" : "ILLEGAL";
      default: return "ILLEGAL";
    endcase
  endfunction

  function automatic logic [25:0] refVector(input logic [15:0] w);
    logic [25:0] v;
    v = '0;
    v[nameIndex(refName(w))] = 1'b1;
    return v;
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [25:0] got, input logic [25:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: outputs=%07h expected=%07h", tag, got, want);
  endtask

  // Present one word just after an edge, clock it in and check the decode.
  task automatic applyStimulus(input logic [15:0] w, input string tag);
    instr = w;
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s(%04h)", tag, w), observed, refVector(w));
  endtask

  logic [15:0] directed [] = '{
    16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0800, 16'h1000, 16'h1800,
    16'h2000, 16'h2800, 16'h3000, 16'h3001, 16'h3800, 16'h4000, 16'h5800,
    16'h8000, 16'h8800, 16'h9000, 16'h9800, 16'hE000, 16'hE001,
    16'hC000, 16'hC100, 16'hC200, 16'hC300, 16'hCE00, 16'hC500,
    16'h3002, 16'hE003, 16'h4800, 16'hF000,
    16'h07FC, 16'h3FFF, 16'h58FF, 16'hCEFF, 16'hC8FF};

  // Fixed expectations for key words, independent of the reference decoder.
  logic [15:0] fixedWord [8] = '{16'h0000, 16'h3001, 16'hCE00, 16'hC500,
                                 16'h07FC, 16'h3FFF, 16'h58FF, 16'hE001};
  int          fixedBit  [8] = '{0, 6, 18, 25, 0, 5, 7, 24};

  initial begin
    logic [15:0] w;
    logic [25:0] held;
    rst   = 1'b1;
    instr = 16'h0000;
    #12;
    checkOutput("reset_all_zero", observed, 26'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_held_over_edge", observed, 26'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_release_before_edge", observed, 26'd0);
    @(posedge clk);
    #1;
    checkOutput("first_edge_ADD", observed, 26'd1);

    foreach (directed[i]) applyStimulus(directed[i], "directed");

    for (int i = 0; i < 8; i++) begin
      instr = fixedWord[i];
      @(posedge clk);
      #1;
      checkOutput($sformatf("fixed_%s", names[fixedBit[i]]), observed, 26'd1 << fixedBit[i]);
    end

    // Changing instr between edges must not disturb the registered outputs.
    applyStimulus(16'h9800, "hold_base");
    held  = refVector(16'h9800);
    instr = 16'hE000;
    #3;
    checkOutput("mid_cycle_change", observed, held);

    // Mid-stream reset clears outputs before the next edge.
    applyStimulus(16'h3800, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_clears", observed, 26'd0);
    instr = 16'hC200;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("decode_after_reset_BCS", observed, 26'd1 << 16);

    // Randomized words, with a share forced into the branch group.
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) w[15:12] = 4'b1100;
      applyStimulus(w, "random");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
